// File: rtl/count_pwm_pkg.sv
// Shared state encoding and defaults for the counter-driven PWM generator.
// Imported by count_pwm_gen and dead_time_gen.
package count_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } pwm_state_t;

  localparam int CNT_W_DEF = 4;
  localparam int DEAD_DEF  = 1;

endpackage

// File: rtl/dead_time_gen.sv
// Splits a raw PWM level into a complementary pair with DEAD both-low cycles at each edge.
// Outputs are registered, so the pair has the same one-cycle latency as the plain pwm output.
module dead_time_gen
  import count_pwm_pkg::*;
#(
  parameter int DEAD = DEAD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_raw,
  output logic pwm,
  output logic pwm_n
);

  if (DEAD > 0) begin : g_dead
    logic [DEAD-1:0] hist;

    // A side turns on only after the raw level has been stable for DEAD cycles,
    // which also swallows pulses too short to survive the gap.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hist  <= '0;
        pwm   <= 1'b0;
        pwm_n <= 1'b0;
      end else begin
        hist[0] <= pwm_raw;
        for (int i = DEAD - 1; i > 0; i--) begin
          hist[i] <= hist[i-1];
        end
        pwm   <= pwm_raw && (&hist);
        pwm_n <= !pwm_raw && !(|hist);
      end
    end
  end else begin : g_no_dead
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pwm   <= 1'b0;
        pwm_n <= 1'b0;
      end else begin
        pwm   <= pwm_raw;
        pwm_n <= !pwm_raw;
      end
    end
  end

endmodule

// File: rtl/count_pwm_gen.sv
// Turns a free-running upstream count into PWM with a shadowed duty applied at each wrap.
// Define PWM_COMP_EN to add the dead-time complementary output pwm_n.
module count_pwm_gen
  import count_pwm_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF,
  parameter int DEAD  = DEAD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count,
  input  logic             duty_valid,
  input  logic [WIDTH-1:0] duty_data,
  output logic             duty_ready,
  output logic             pwm,
  output logic             period_start
`ifdef PWM_COMP_EN
  ,
  output logic             pwm_n
`endif
);

  pwm_state_t       state;
  pwm_state_t       next_state;
  logic [WIDTH-1:0] prev_count;
  logic [WIDTH-1:0] duty_active;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] duty_eff;
  logic             shadow_full;
  logic             wrap;
  logic             accept;
  logic             pwm_raw;

  // Any step to zero counts, so an upstream counter reset also starts a new period.
  assign wrap       = (count == '0) && (prev_count != '0);
  assign duty_ready = (state == IDLE) ? 1'b1 : !shadow_full;
  assign accept     = duty_valid && duty_ready;
  assign duty_eff   = (wrap && shadow_full) ? shadow : duty_active;

  always_comb begin
    next_state = state;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = ARMED;
        ARMED:   if (wrap) next_state = RUN;
        RUN:     next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  assign pwm_raw = (next_state == RUN) && (count < duty_eff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      prev_count   <= '0;
      duty_active  <= '0;
      shadow       <= '0;
      shadow_full  <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= next_state;
      prev_count   <= count;
      period_start <= wrap && (state != IDLE) && en;

      if (accept && (state == IDLE)) begin
        duty_active <= duty_data;
      end else if (wrap && shadow_full) begin
        duty_active <= shadow;
      end

      // A write landing on the wrap edge stays in the shadow until the next wrap.
      if (accept && (state != IDLE)) begin
        shadow      <= duty_data;
        shadow_full <= 1'b1;
      end else if (wrap && shadow_full) begin
        shadow_full <= 1'b0;
      end
    end
  end

`ifdef PWM_COMP_EN
  dead_time_gen #(
    .DEAD (DEAD)
  ) u_dead_time (
    .clk     (clk),
    .rst     (rst),
    .pwm_raw (pwm_raw),
    .pwm     (pwm),
    .pwm_n   (pwm_n)
  );
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= pwm_raw;
    end
  end

  // DEAD only shapes the complementary pair; this build accepts and ignores it.
  if (DEAD < 0) begin : g_dead_unused
  end
`endif

endmodule
